// File: rtl/if_stage_if.sv
// Bundle of the fetch stage's non-clock signals: decode feedback, program-load
// handshake, run control and the IF/ID outputs.
interface if_stage_if #(
  parameter int unsigned PC_SIZE  = 32,
  parameter int unsigned BUS_SIZE = 32
);
  logic                i_enable;
  logic                i_flush;
  logic                i_next_pc_src;
  logic [PC_SIZE-1:0]  i_next_not_seq_pc;
  logic                i_load_valid;
  logic [BUS_SIZE-1:0] i_load_data;
  logic                i_start;
  logic                i_clear;
  logic                o_load_ready;
  logic                o_mem_full;
  logic [BUS_SIZE-1:0] o_instruction;
  logic [PC_SIZE-1:0]  o_next_seq_pc;
  logic [PC_SIZE-1:0]  o_pc;
  logic                o_halt;

  modport master (
    output i_enable, i_flush, i_next_pc_src, i_next_not_seq_pc,
           i_load_valid, i_load_data, i_start, i_clear,
    input  o_load_ready, o_mem_full, o_instruction, o_next_seq_pc, o_pc, o_halt
  );

  modport slave (
    input  i_enable, i_flush, i_next_pc_src, i_next_not_seq_pc,
           i_load_valid, i_load_data, i_start, i_clear,
    output o_load_ready, o_mem_full, o_instruction, o_next_seq_pc, o_pc, o_halt
  );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage with loadable instruction memory, IF/ID latch and
// IDLE/RUN/HALTED run control.
module if_stage #(
  parameter int unsigned PC_SIZE        = 32,
  parameter int unsigned BUS_SIZE       = 32,
  parameter int unsigned MEM_SIZE_WORDS = 64
) (
  input  logic    i_clk,
  input  logic    i_reset,
  if_stage_if.slave bus
);
  localparam int unsigned AW = $clog2(MEM_SIZE_WORDS);

  typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;

  state_t              state, state_next;
  logic [BUS_SIZE-1:0] imem [MEM_SIZE_WORDS];
  logic [PC_SIZE-1:0]  pc, pc_seq, next_seq_pc;
  logic [BUS_SIZE-1:0] instruction, fetch_word;
  logic [AW:0]         wr_ptr;
  logic                load_ready, halt, load_we, advance, halt_hit, clear_all;

  assign pc_seq     = pc + PC_SIZE'(4);
  assign fetch_word = imem[pc[AW+1:2]];
  assign load_we    = (state == IDLE) && bus.i_load_valid && load_ready;
  assign advance    = (state == RUN) && bus.i_enable;
  // Halt only on a plain sequential advance; branch or flush wins.
  assign halt_hit   = advance && !bus.i_flush && !bus.i_next_pc_src && (fetch_word == '1);
  assign clear_all  = (state == HALTED) && bus.i_clear;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.i_start) state_next = RUN;
      RUN:     if (halt_hit)    state_next = HALTED;
      HALTED:  if (bus.i_clear) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    load_ready = 1'b0;
    halt       = 1'b0;
    case (state)
      IDLE:    load_ready = !wr_ptr[AW];
      HALTED:  halt       = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      pc          <= '0;
      wr_ptr      <= '0;
      instruction <= '0;
      next_seq_pc <= '0;
    end else if (clear_all) begin
      pc          <= '0;
      wr_ptr      <= '0;
      instruction <= '0;
      next_seq_pc <= '0;
    end else begin
      if (load_we) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (advance) begin
        next_seq_pc <= pc_seq;
        instruction <= bus.i_flush ? '0 : fetch_word;
        if (!halt_hit) pc <= bus.i_next_pc_src ? bus.i_next_not_seq_pc : pc_seq;
      end
    end
  end

  // Program memory is deliberately left out of reset so a reset keeps the program.
  always_ff @(posedge i_clk) begin
    if (load_we) imem[wr_ptr[AW-1:0]] <= bus.i_load_data;
  end

  assign bus.o_load_ready  = load_ready;
  assign bus.o_mem_full    = wr_ptr[AW];
  assign bus.o_instruction = instruction;
  assign bus.o_next_seq_pc = next_seq_pc;
  assign bus.o_pc          = pc;
  assign bus.o_halt        = halt;
endmodule

// File: tb/tb_if_stage.sv
// Directed plus random checks of if_stage against a behavioural program/PC model.
module tb_if_stage;
  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  if_stage_if #(.PC_SIZE(32), .BUS_SIZE(32)) bus ();

  if_stage #(.PC_SIZE(32), .BUS_SIZE(32), .MEM_SIZE_WORDS(64)) dut (
    .i_clk   (clk),
    .i_reset (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: program array, write count, pc, IF/ID contents, mode name.
  logic [31:0] m_mem [64];
  int          m_wr;
  logic [31:0] m_pc, m_ir, m_nsp;
  string       m_mode;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    m_mode = "IDLE";
    m_pc = 0; m_wr = 0; m_ir = 0; m_nsp = 0;
  endtask

  task automatic model_step();
    logic [31:0] fw;
    bit          hit;
    if (m_mode == "IDLE") begin
      if (bus.i_load_valid && m_wr < 64) begin
        m_mem[m_wr] = bus.i_load_data;
        m_wr++;
      end
      if (bus.i_start) m_mode = "RUN";
    end else if (m_mode == "RUN") begin
      if (bus.i_enable) begin
        fw    = m_mem[(m_pc / 4) % 64];
        hit   = !bus.i_flush && !bus.i_next_pc_src && (fw == 32'hFFFF_FFFF);
        m_nsp = m_pc + 4;
        m_ir  = bus.i_flush ? 32'h0 : fw;
        if (hit) m_mode = "HALTED";
        else     m_pc = bus.i_next_pc_src ? bus.i_next_not_seq_pc : m_pc + 4;
      end
    end else if (bus.i_clear) begin
      model_reset();
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pc"},    bus.o_pc,          m_pc);
    chk({tag, ".ir"},    bus.o_instruction, m_ir);
    chk({tag, ".nsp"},   bus.o_next_seq_pc, m_nsp);
    chk({tag, ".halt"},  32'(bus.o_halt),       32'(m_mode == "HALTED"));
    chk({tag, ".ready"}, 32'(bus.o_load_ready), 32'(m_mode == "IDLE" && m_wr < 64));
    chk({tag, ".full"},  32'(bus.o_mem_full),   32'(m_wr == 64));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    #1;
    model_step();
    check_all(tag);
  endtask

  task automatic idle_inputs();
    bus.i_enable = 0; bus.i_flush = 0; bus.i_next_pc_src = 0; bus.i_next_not_seq_pc = 0;
    bus.i_load_valid = 0; bus.i_load_data = 0; bus.i_start = 0; bus.i_clear = 0;
  endtask

  task automatic pulse_reset();
    idle_inputs();
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    model_reset();
  endtask

  logic [31:0] prog [4];
  logic [31:0] w;

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    #12;
    check_all("reset");
    rst_n = 1'b1;

    // Load A..D, the last together with start, then run four advances.
    for (int i = 0; i < 4; i++) begin
      prog[i] = $urandom & 32'h7FFF_FFFF;
      bus.i_load_valid = 1; bus.i_load_data = prog[i]; bus.i_start = (i == 3);
      step("load4");
    end
    idle_inputs();
    bus.i_enable = 1;
    for (int i = 0; i < 4; i++) begin
      step("run4");
      chk("seq_ir",  bus.o_instruction, prog[i]);
      chk("seq_nsp", bus.o_next_seq_pc, 32'(4 * (i + 1)));
    end

    // Fill all 64 words (word 3 is HALT), then one dropped extra word.
    pulse_reset();
    for (int i = 0; i < 64; i++) begin
      w = (i == 3) ? 32'hFFFF_FFFF : ($urandom & 32'h7FFF_FFFF);
      bus.i_load_valid = 1; bus.i_load_data = w;
      step("fill");
    end
    bus.i_load_data = 32'hDEAD_BEEF;
    step("overflow");
    chk("full_flag", 32'(bus.o_mem_full), 32'd1);
    bus.i_load_valid = 0; bus.i_start = 1;
    step("start");
    bus.i_start = 0;

    // Stall: branch/flush must have no effect.
    for (int i = 0; i < 3; i++) begin
      bus.i_enable = 0; bus.i_flush = 1; bus.i_next_pc_src = 1; bus.i_next_not_seq_pc = $urandom;
      step("stall");
      chk("stall_pc", bus.o_pc, 32'h0);
    end
    idle_inputs();
    bus.i_enable = 1;
    step("adv0");
    step("adv1");
    bus.i_next_pc_src = 1; bus.i_next_not_seq_pc = 32'h20;
    step("branch");
    chk("br_pc",  bus.o_pc,          32'h20);
    chk("br_nsp", bus.o_next_seq_pc, 32'd12);
    bus.i_next_pc_src = 0; bus.i_flush = 1;
    step("flush");
    chk("flush_ir", bus.o_instruction, 32'h0);
    bus.i_flush = 0; bus.i_next_pc_src = 1; bus.i_next_not_seq_pc = 32'd12;
    step("to_halt");
    bus.i_next_pc_src = 0;
    step("halt");
    chk("halt_ir", bus.o_instruction, 32'hFFFF_FFFF);
    chk("halt_pc", bus.o_pc, 32'd12);
    chk("halt_o",  32'(bus.o_halt), 32'd1);
    step("halted");
    bus.i_enable = 0; bus.i_clear = 1;
    step("clear");
    chk("clear_ready", 32'(bus.o_load_ready), 32'd1);
    chk("clear_pc",    bus.o_pc, 32'h0);

    // Random traffic against the model; memory is fully defined from the fill.
    for (int i = 0; i < 600; i++) begin
      bus.i_enable          = ($urandom % 4) != 0;
      bus.i_flush           = ($urandom % 5) == 0;
      bus.i_next_pc_src     = ($urandom % 4) == 0;
      bus.i_next_not_seq_pc = (($urandom % 8) == 0) ? 32'hFFFF_FFFC : $urandom;
      bus.i_load_valid      = $urandom % 2;
      bus.i_load_data       = (($urandom % 16) == 0) ? 32'hFFFF_FFFF : $urandom;
      bus.i_start           = ($urandom % 6) == 0;
      bus.i_clear           = ($urandom % 4) == 0;
      step("rand");
    end

    // PC wrap at all-ones, then asynchronous reset between edges.
    pulse_reset();
    bus.i_start = 1;
    step("wstart");
    idle_inputs();
    bus.i_enable = 1; bus.i_next_pc_src = 1; bus.i_next_not_seq_pc = 32'hFFFF_FFFC;
    step("wbr");
    bus.i_next_pc_src = 0;
    step("wrap");
    step("wrap2");
    idle_inputs();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    #2 rst_n = 1'b1;
    bus.i_start = 1;
    step("rs_start");
    bus.i_start = 0; bus.i_enable = 1;
    step("rs_adv");
    chk("mem_intact", bus.o_instruction, m_mem[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
